reg_file_mp: RTL



---
 rtl/reg_file_pkg.sv | 20 ++
 rtl/reg_file_init_ctrl.sv | 60 ++++++
 rtl/reg_file_mp.sv | 86 ++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the multi-read-port register file.
// State enum, default geometry and the packed read-port slice helper.
package reg_file_pkg;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_ADDR_W = 5;
   localparam int unsigned DEF_NUM_RD = 2;

   // LSB position of port `port` in a packed bus of `width`-bit fields.
   function automatic int unsigned port_lsb(input int unsigned port,
                                            input int unsigned width);
      return port * width;
   endfunction

endpackage

// File: rtl/reg_file_init_ctrl.sv
// Init/clear sequencer: walks every address once, writing zero, then
// hands the array over to the user write port.
module reg_file_init_ctrl
   import reg_file_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   output logic              busy,
   output logic              sweep_we,
   output logic [ADDR_W-1:0] sweep_addr
);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         ST_INIT: begin
            // clr is deliberately not sampled here: a running sweep is never restarted
            cnt_nxt = cnt + 1'b1;
            if (cnt == '1) begin
               state_nxt = ST_READY;
               cnt_nxt   = '0;
            end
         end
         ST_READY: begin
            if (clr) begin
               state_nxt = ST_INIT;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = ST_INIT;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      busy       = (state == ST_INIT);
      sweep_we   = (state == ST_INIT);
      sweep_addr = cnt;
   end

endmodule

// File: rtl/reg_file_mp.sv
// Register file with NUM_RD combinational read ports, one write port and a
// hardware clear sweep. Define REG_FILE_BYPASS_EN for same-cycle write forwarding.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned NUM_RD   = DEF_NUM_RD,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     clr,
   output logic                     busy
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              sweep_we;
   logic [ADDR_W-1:0] sweep_addr;
   logic              wr_to_zero;
   logic              user_we;
   logic              arr_we;
   logic [ADDR_W-1:0] arr_addr;
   logic [DATA_W-1:0] arr_data;

   reg_file_init_ctrl #(
      .ADDR_W (ADDR_W)
   ) u_init_ctrl (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .busy       (busy),
      .sweep_we   (sweep_we),
      .sweep_addr (sweep_addr)
   );

   // A write coinciding with clr is dropped, as is any write while sweeping.
   always_comb begin
      wr_to_zero = (ZERO_REG != 0) && (wr_addr == '0);
      user_we    = wr_en && !busy && !clr && !wr_to_zero;
      arr_we     = sweep_we || user_we;
      arr_addr   = sweep_we ? sweep_addr : wr_addr;
      arr_data   = sweep_we ? '0 : wr_data;
   end

   // No reset on the array; the sweep zeroes it instead.
   always_ff @(posedge clk) begin
      if (arr_we) begin
         mem[arr_addr] <= arr_data;
      end
   end

   logic [ADDR_W-1:0] port_addr;
   logic [DATA_W-1:0] port_val;

   always_comb begin
      rd_data   = '0;
      port_addr = '0;
      port_val  = '0;
      for (int unsigned i = 0; i < NUM_RD; i++) begin
         port_addr = rd_addr[port_lsb(i, ADDR_W) +: ADDR_W];
         port_val  = mem[port_addr];
`ifdef REG_FILE_BYPASS_EN
         if (user_we && (wr_addr == port_addr)) begin
            port_val = wr_data;
         end
`endif
         if ((ZERO_REG != 0) && (port_addr == '0)) begin
            port_val = '0;
         end
         if (busy) begin
            port_val = '0;
         end
         rd_data[port_lsb(i, DATA_W) +: DATA_W] = port_val;
      end
   end

endmodule
